// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: operation codes and FSM state encoding.
package seq_alu_pkg;

    // Operation codes carried on the op port.
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_MUL = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } op_e;

    // Control FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/seq_alu_mul.sv
// Shift-add unsigned multiplier: one multiplier bit per step, WIDTH steps per product.
// o_prod_nxt is the partial product that the current step would store, so the
// parent can capture the finished product on the same edge as the last step.
module seq_alu_mul #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_step,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_last,
    output logic [2*WIDTH-1:0]   o_prod_nxt
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_prod;

    assign o_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : '0);
    assign o_last     = i_step && (r_cnt == LAST_CNT);

    // Load operands on start, then add-and-shift once per step.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
        end else if (i_start) begin
            r_cnt    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, i_a};
            r_mplier <= i_b;
            r_prod   <= '0;
        end else if (i_step) begin
            r_prod   <= o_prod_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready request and result handshakes.
// Handshake: a request is taken on a rising edge where in_valid && in_ready;
// a result is presented while out_valid is high and is released on the edge
// where out_ready is high. The result and flags stay frozen until released,
// and no new request is taken on the release edge.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] o,
    output logic             cout,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output state_e           o_dbg_state
);

    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    state_e             r_state;
    logic [WIDTH-1:0]   r_o;
    logic               r_cout;
    logic               r_zero;
    logic               r_neg;
    logic               r_ovf;

    logic               w_accept;
    logic               w_is_mul;
    logic [SHW-1:0]     w_shamt;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_sub;
    logic [WIDTH:0]     w_shl;
    logic [WIDTH:0]     w_shr;
    logic [WIDTH-1:0]   w_res;
    logic               w_cout;
    logic               w_ovf;
    logic               w_mul_last;
    logic [2*WIDTH-1:0] w_mul_prod;
    logic [WIDTH-1:0]   w_mul_lo;

    assign in_ready    = reset && (r_state == ST_IDLE);
    assign w_accept    = in_valid && in_ready;
    assign w_is_mul    = (op_e'(op) == OP_MUL);
    assign out_valid   = (r_state == ST_DONE);
    assign o           = r_o;
    assign cout        = r_cout;
    assign zero        = r_zero;
    assign neg         = r_neg;
    assign ovf         = r_ovf;
    assign o_dbg_state = r_state;

    // Extra top/bottom bit catches the carry, borrow or last shifted-out bit.
    assign w_shamt = i1[SHW-1:0];
    assign w_add   = {1'b0, i0} + {1'b0, i1};
    assign w_sub   = {1'b0, i0} - {1'b0, i1};
    assign w_shl   = {1'b0, i0} << w_shamt;
    assign w_shr   = {i0, 1'b0} >> w_shamt;
    assign w_mul_lo = w_mul_prod[WIDTH-1:0];

    // Single-cycle operations; MUL goes through the shift-add unit instead.
    always_comb begin
        w_res  = '0;
        w_cout = 1'b0;
        w_ovf  = 1'b0;
        case (op_e'(op))
            OP_ADD: begin
                w_res  = w_add[WIDTH-1:0];
                w_cout = w_add[WIDTH];
                w_ovf  = (i0[MSB] == i1[MSB]) && (w_add[MSB] != i0[MSB]);
            end
            OP_SUB: begin
                w_res  = w_sub[WIDTH-1:0];
                w_cout = w_sub[WIDTH];
                w_ovf  = (i0[MSB] != i1[MSB]) && (w_sub[MSB] != i0[MSB]);
            end
            OP_AND: w_res = i0 & i1;
            OP_OR:  w_res = i0 | i1;
            OP_XOR: w_res = i0 ^ i1;
            OP_SHL: begin
                w_res  = w_shl[WIDTH-1:0];
                w_cout = w_shl[WIDTH];
            end
            OP_SHR: begin
                w_res  = w_shr[WIDTH:1];
                w_cout = w_shr[0];
            end
            default: begin
                w_res  = '0;
                w_cout = 1'b0;
                w_ovf  = 1'b0;
            end
        endcase
    end

    seq_alu_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk        (clk),
        .i_rst_n    (reset),
        .i_start    (w_accept && w_is_mul),
        .i_step     (r_state == ST_BUSY),
        .i_a        (i0),
        .i_b        (i1),
        .o_last     (w_mul_last),
        .o_prod_nxt (w_mul_prod)
    );

    // Control FSM with registered result and flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_o     <= '0;
            r_cout  <= 1'b0;
            r_zero  <= 1'b0;
            r_neg   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_is_mul) begin
                            r_state <= ST_BUSY;
                        end else begin
                            r_state <= ST_DONE;
                            r_o     <= w_res;
                            r_cout  <= w_cout;
                            r_zero  <= (w_res == '0);
                            r_neg   <= w_res[MSB];
                            r_ovf   <= w_ovf;
                        end
                    end
                end
                ST_BUSY: begin
                    if (w_mul_last) begin
                        r_state <= ST_DONE;
                        r_o     <= w_mul_lo;
                        r_cout  <= |w_mul_prod[2*WIDTH-1:WIDTH];
                        r_zero  <= (w_mul_lo == '0);
                        r_neg   <= w_mul_lo[MSB];
                        r_ovf   <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed vector table, reset-during-MUL
// sequence and randomized operations against an arithmetic reference model.
module tb_seq_alu;
    import seq_alu_pkg::*;

    localparam int W = 16;

    logic         clk;
    logic         reset;
    logic [2:0]   op;
    logic [W-1:0] i0;
    logic [W-1:0] i1;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] o;
    logic         cout;
    logic         zero;
    logic         neg;
    logic         ovf;
    logic         out_valid;
    logic         out_ready;
    state_e       dbg_state;

    int n_cmp;
    int n_fail;

    // Expected results, packed as {o, cout, zero, neg, ovf}.
    logic [W+3:0] exp_q[$];

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W+3:0] exp;
        int           hold;
    } vec_t;

    seq_alu #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .i0          (i0),
        .i1          (i1),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .o           (o),
        .cout        (cout),
        .zero        (zero),
        .neg         (neg),
        .ovf         (ovf),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .o_dbg_state (dbg_state)
    );

    // Clock and global time limit.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model from the arithmetic definition of each operation.
    function automatic logic [W+3:0] ref_model(input logic [2:0] p, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned full;
        longint          sa;
        longint          sb;
        longint          s;
        longint          smax;
        longint          smin;
        int              sh;
        logic [W-1:0]    r;
        logic            c;
        logic            v;
        ua   = longint'(a);
        ub   = longint'(b);
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        smax = (longint'(1) << (W - 1)) - 1;
        smin = -(longint'(1) << (W - 1));
        sh   = int'(ub % W);
        full = 0;
        r    = '0;
        c    = 1'b0;
        v    = 1'b0;
        case (p)
            3'd0: begin
                full = ua + ub;
                r = W'(full);
                c = (full >> W) != 0;
                s = sa + sb;
                v = (s > smax) || (s < smin);
            end
            3'd1: begin
                full = ua - ub;
                r = W'(full);
                c = ua < ub;
                s = sa - sb;
                v = (s > smax) || (s < smin);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin
                full = ua * ub;
                r = W'(full);
                c = (full >> W) != 0;
            end
            3'd6: begin
                r = W'(ua << sh);
                c = (sh == 0) ? 1'b0 : 1'((ua >> (W - sh)) & 1);
            end
            default: begin
                r = W'(ua >> sh);
                c = (sh == 0) ? 1'b0 : 1'((ua >> (sh - 1)) & 1);
            end
        endcase
        return {r, c, (r == '0), r[W-1], v};
    endfunction

    // Driver: issue one request, check latency and result, optionally stall
    // the consumer for hold cycles while poking in_valid, then release.
    task automatic run_op(input logic [2:0] p_op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W+3:0] exp, input int hold, input string tag);
        int           wait_cnt;
        int           lat;
        int           exp_lat;
        logic [W+3:0] want;
        wait_cnt = 0;
        while (in_ready !== 1'b1 && wait_cnt < 50) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
        op       = p_op;
        i0       = a;
        i1       = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_q.push_back(exp);
        exp_lat = (p_op == 3'd5) ? W + 1 : 1;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        want = exp_q.pop_front();
        chk({tag, " result"}, 64'({o, cout, zero, neg, ovf}), 64'(want));
        chk({tag, " busy in_ready"}, 64'(in_ready), 64'd0);
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            op       = 3'($urandom_range(0, 7));
            i0       = W'($urandom);
            i1       = W'($urandom);
            @(posedge clk); #1;
            chk($sformatf("%s hold%0d result", tag, k), 64'({o, cout, zero, neg, ovf}), 64'(want));
            chk($sformatf("%s hold%0d out_valid", tag, k), 64'(out_valid), 64'd1);
            chk($sformatf("%s hold%0d in_ready", tag, k), 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk({tag, " released out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, " released state"}, 64'(dbg_state), 64'(ST_IDLE));
        chk({tag, " released in_ready"}, 64'(in_ready), 64'd1);
    endtask

    vec_t vecs[15];

    initial begin
        logic [2:0]   r_op;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           seen;

        n_cmp     = 0;
        n_fail    = 0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = '0;
        i0        = '0;
        i1        = '0;

        vecs[0]  = '{3'd0, 16'haa55, 16'h55aa, {16'hffff, 4'b0010}, 5};
        vecs[1]  = '{3'd0, 16'hffff, 16'h0001, {16'h0000, 4'b1100}, 0};
        vecs[2]  = '{3'd1, 16'h0001, 16'h7fff, {16'h8002, 4'b1010}, 0};
        vecs[3]  = '{3'd5, 16'h00ff, 16'h0101, {16'hffff, 4'b0010}, 0};
        vecs[4]  = '{3'd5, 16'hffff, 16'h0002, {16'hfffe, 4'b1010}, 2};
        vecs[5]  = '{3'd6, 16'h8001, 16'h0001, {16'h0002, 4'b1000}, 0};
        vecs[6]  = '{3'd7, 16'h0001, 16'h0000, {16'h0001, 4'b0000}, 0};
        vecs[7]  = '{3'd0, 16'h7fff, 16'h0001, {16'h8000, 4'b0011}, 0};
        vecs[8]  = '{3'd1, 16'h8000, 16'h0001, {16'h7fff, 4'b0001}, 0};
        vecs[9]  = '{3'd2, 16'hf0f0, 16'hff00, {16'hf000, 4'b0010}, 0};
        vecs[10] = '{3'd3, 16'h0f00, 16'h00f0, {16'h0ff0, 4'b0000}, 0};
        vecs[11] = '{3'd4, 16'hffff, 16'hffff, {16'h0000, 4'b0100}, 0};
        vecs[12] = '{3'd7, 16'h8000, 16'h001f, {16'h0001, 4'b0000}, 0};
        vecs[13] = '{3'd6, 16'h0003, 16'h0010, {16'h0003, 4'b0000}, 0};
        vecs[14] = '{3'd5, 16'h0000, 16'h1234, {16'h0000, 4'b0100}, 1};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", 64'({o, cout, zero, neg, ovf, out_valid}), 64'd0);
        chk("reset in_ready", 64'(in_ready), 64'd0);
        chk("reset state", 64'(dbg_state), 64'(ST_IDLE));
        reset = 1'b1;
        #1;
        chk("post-reset in_ready", 64'(in_ready), 64'd1);

        // Directed vectors.
        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].hold,
                   $sformatf("vec%0d", i));
        end

        // Reset in the middle of a multiply abandons it.
        op       = 3'd5;
        i0       = 16'h00ff;
        i1       = 16'h0101;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mulrst busy", 64'(dbg_state), 64'(ST_BUSY));
        reset = 1'b0;
        #1;
        chk("mulrst in_ready low", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        chk("mulrst outputs", 64'({o, cout, zero, neg, ovf, out_valid}), 64'd0);
        chk("mulrst state", 64'(dbg_state), 64'(ST_IDLE));
        reset = 1'b1;
        #1;
        chk("mulrst in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen++;
        end
        chk("mulrst no stale result", 64'(seen), 64'd0);
        run_op(3'd0, 16'h0001, 16'h0001, {16'h0002, 4'b0000}, 0, "after_rst add");

        // Randomized operations against the reference model.
        for (int i = 0; i < 60; i++) begin
            r_op = 3'($urandom_range(0, 7));
            ra   = W'($urandom);
            rb   = W'($urandom);
            if (i % 7 == 0) rb = W'($urandom_range(0, 3));
            run_op(r_op, ra, rb, ref_model(r_op, ra, rb), $urandom_range(0, 2),
                   $sformatf("rnd%0d op%0d %h,%h", i, r_op, ra, rb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
